// File: rtl/id_stage_pipe_pkg.sv
// Shared decode constants and types for the instruction-decode stage.
// Holds status bit positions, execute commands and condition codes.
package id_stage_pipe_pkg;

    localparam int REG_ADDR_W = 4;

    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

    localparam logic [1:0] MODE_ALU = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    typedef enum logic [3:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
        CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
        CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
        CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic       s;
        logic       b;
        logic [3:0] exe_cmd;
        logic       mem_w_en;
        logic       mem_r_en;
        logic       wb_en;
    } ctrl_t;

endpackage

// File: rtl/id_ctrl.sv
// Opcode controller and condition-code checker used by the decode stage.
// Both are purely combinational.
module id_controller
    import id_stage_pipe_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [3:0] opcode,
    input  logic       s_bit,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        unique case (mode)
            MODE_ALU: begin
                ctrl.s     = s_bit;
                ctrl.wb_en = 1'b1;
                unique case (opcode)
                    4'b1101: ctrl.exe_cmd = EXE_MOV;
                    4'b1111: ctrl.exe_cmd = EXE_MVN;
                    4'b0100: ctrl.exe_cmd = EXE_ADD;
                    4'b0101: ctrl.exe_cmd = EXE_ADC;
                    4'b0010: ctrl.exe_cmd = EXE_SUB;
                    4'b0110: ctrl.exe_cmd = EXE_SBC;
                    4'b0000: ctrl.exe_cmd = EXE_AND;
                    4'b1100: ctrl.exe_cmd = EXE_ORR;
                    4'b0001: ctrl.exe_cmd = EXE_EOR;
                    4'b1010: begin
                        ctrl.exe_cmd = EXE_SUB;
                        ctrl.wb_en   = 1'b0;
                    end
                    4'b1000: begin
                        ctrl.exe_cmd = EXE_AND;
                        ctrl.wb_en   = 1'b0;
                    end
                    default: begin
                        ctrl.exe_cmd = EXE_NOP;
                        ctrl.wb_en   = 1'b0;
                    end
                endcase
            end
            // s_bit is the load/store selector in memory mode
            MODE_MEM: begin
                ctrl.exe_cmd  = EXE_ADD;
                ctrl.mem_r_en = s_bit;
                ctrl.wb_en    = s_bit;
                ctrl.mem_w_en = ~s_bit;
            end
            MODE_BR: ctrl.b = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

module id_cond_check
    import id_stage_pipe_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       pass
);

    logic n, z, c, v;

    always_comb begin
        n    = status[ST_N];
        z    = status[ST_Z];
        c    = status[ST_C];
        v    = status[ST_V];
        pass = 1'b0;
        unique case (cond_e'(cond))
            CC_EQ: pass = z;
            CC_NE: pass = ~z;
            CC_CS: pass = c;
            CC_CC: pass = ~c;
            CC_MI: pass = n;
            CC_PL: pass = ~n;
            CC_VS: pass = v;
            CC_VC: pass = ~v;
            CC_HI: pass = c & ~z;
            CC_LS: pass = ~c | z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = ~z & (n == v);
            CC_LE: pass = z | (n != v);
            CC_AL: pass = 1'b1;
            CC_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe_regfile.sv
// 16-entry register file: async reads, multi-port sync writes,
// optional write-to-read forwarding.
module id_regfile
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int WB_PORTS = 1,
    parameter int BYPASS   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WB_PORTS-1:0]            wb_en,
    input  logic [REG_ADDR_W*WB_PORTS-1:0] wb_dest,
    input  logic [DATA_W*WB_PORTS-1:0]     wb_value,
    input  logic [REG_ADDR_W-1:0]          rn_addr,
    input  logic [REG_ADDR_W-1:0]          rm_addr,
    output logic [DATA_W-1:0]              rn_value,
    output logic [DATA_W-1:0]              rm_value
);

    logic [DATA_W-1:0] regs [16];

    // Later ports are applied last, so the highest index wins a collision
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < WB_PORTS; k++) begin
                if (wb_en[k]) begin
                    regs[wb_dest[k*REG_ADDR_W +: REG_ADDR_W]] <=
                        wb_value[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        rn_value = regs[rn_addr];
        rm_value = regs[rm_addr];
        if (BYPASS != 0) begin
            for (int k = 0; k < WB_PORTS; k++) begin
                if (wb_en[k] &&
                    wb_dest[k*REG_ADDR_W +: REG_ADDR_W] == rn_addr) begin
                    rn_value = wb_value[k*DATA_W +: DATA_W];
                end
                if (wb_en[k] &&
                    wb_dest[k*REG_ADDR_W +: REG_ADDR_W] == rm_addr) begin
                    rm_value = wb_value[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: register read, control decode, condition check and
// a small output FIFO toward execute.
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int WB_PORTS = 1,
    parameter int DEPTH    = 2,
    parameter int BYPASS   = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    instruction,
    input  logic [DATA_W-1:0]              pc_in,
    input  logic                           flush,
    input  logic                           hazard,
    input  logic [3:0]                     status,
    input  logic [WB_PORTS-1:0]            wb_en,
    input  logic [REG_ADDR_W*WB_PORTS-1:0] wb_dest,
    input  logic [DATA_W*WB_PORTS-1:0]     wb_value,
    output logic [REG_ADDR_W-1:0]          rn_addr,
    output logic [REG_ADDR_W-1:0]          rm_addr,
    output logic                           two_src,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [3:0]                     dest,
    output logic [23:0]                    branch_imm,
    output logic                           imm,
    output logic [11:0]                    shift_operand,
    output logic [DATA_W-1:0]              rn_value,
    output logic [DATA_W-1:0]              rm_value,
    output logic [DATA_W-1:0]              pc,
    output logic                           s,
    output logic                           b,
    output logic [3:0]                     exe_cmd,
    output logic                           mem_w_en,
    output logic                           mem_r_en,
    output logic                           wb_en_out,
    output logic                           carry
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [3:0]        dest;
        logic [23:0]       branch_imm;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [DATA_W-1:0] rn_value;
        logic [DATA_W-1:0] rm_value;
        logic [DATA_W-1:0] pc;
        ctrl_t             ctrl;
        logic              carry;
    } entry_t;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    ctrl_t             ctrl_raw;
    logic              cond_ok;
    logic [DATA_W-1:0] rd_rn;
    logic [DATA_W-1:0] rd_rm;
    entry_t            entry;
    entry_t            head;
    entry_t            buf_q [DEPTH];
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    id_controller u_ctrl (
        .mode   (instruction[27:26]),
        .opcode (instruction[24:21]),
        .s_bit  (instruction[20]),
        .ctrl   (ctrl_raw)
    );

    id_cond_check u_cond (
        .cond   (instruction[31:28]),
        .status (status),
        .pass   (cond_ok)
    );

    id_regfile #(
        .DATA_W   (DATA_W),
        .WB_PORTS (WB_PORTS),
        .BYPASS   (BYPASS)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en),
        .wb_dest  (wb_dest),
        .wb_value (wb_value),
        .rn_addr  (rn_addr),
        .rm_addr  (rm_addr),
        .rn_value (rd_rn),
        .rm_value (rd_rm)
    );

    assign rn_addr = instruction[19:16];
    assign rm_addr = ctrl_raw.mem_w_en ? instruction[15:12]
                                       : instruction[3:0];
    assign two_src = ~instruction[25] | ctrl_raw.mem_w_en;

    assign in_ready = rst & (count < CNT_W'(DEPTH)) & ~hazard & ~flush;
    assign out_valid = (count != '0);
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready & ~flush;

    always_comb begin
        entry               = '0;
        entry.dest          = instruction[15:12];
        entry.branch_imm    = instruction[23:0];
        entry.imm           = instruction[25];
        entry.shift_operand = instruction[11:0];
        entry.rn_value      = rd_rn;
        entry.rm_value      = rd_rm;
        entry.pc            = pc_in;
        entry.ctrl          = cond_ok ? ctrl_raw : '0;
        entry.carry         = status[ST_C];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= entry;
                wr_ptr        <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Empty buffer presents an all-zero bundle
    assign head = out_valid ? buf_q[rd_ptr] : '0;

    assign dest          = head.dest;
    assign branch_imm    = head.branch_imm;
    assign imm           = head.imm;
    assign shift_operand = head.shift_operand;
    assign rn_value      = head.rn_value;
    assign rm_value      = head.rm_value;
    assign pc            = head.pc;
    assign s             = head.ctrl.s;
    assign b             = head.ctrl.b;
    assign exe_cmd       = head.ctrl.exe_cmd;
    assign mem_w_en      = head.ctrl.mem_w_en;
    assign mem_r_en      = head.ctrl.mem_r_en;
    assign wb_en_out     = head.ctrl.wb_en;
    assign carry         = head.carry;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Randomized bench for id_stage_pipe with an in-bench behavioural model
// (register array + expected-entry queue) and a few literal scenarios.
module tb_id_stage_pipe;

    localparam int DW = 32;
    localparam int NP = 2;
    localparam int DP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instruction;
    logic [DW-1:0] pc_in;
    logic          flush;
    logic          hazard;
    logic [3:0]    status;
    logic [NP-1:0] wb_en;
    logic [4*NP-1:0] wb_dest;
    logic [DW*NP-1:0] wb_value;
    logic [3:0]    rn_addr;
    logic [3:0]    rm_addr;
    logic          two_src;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    dest;
    logic [23:0]   branch_imm;
    logic          imm;
    logic [11:0]   shift_operand;
    logic [DW-1:0] rn_value;
    logic [DW-1:0] rm_value;
    logic [DW-1:0] pc;
    logic          s;
    logic          b;
    logic [3:0]    exe_cmd;
    logic          mem_w_en;
    logic          mem_r_en;
    logic          wb_en_out;
    logic          carry;

    id_stage_pipe #(
        .DATA_W(DW), .WB_PORTS(NP), .DEPTH(DP), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_in(pc_in),
        .flush(flush), .hazard(hazard), .status(status),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .rn_addr(rn_addr), .rm_addr(rm_addr), .two_src(two_src),
        .out_valid(out_valid), .out_ready(out_ready),
        .dest(dest), .branch_imm(branch_imm), .imm(imm),
        .shift_operand(shift_operand),
        .rn_value(rn_value), .rm_value(rm_value), .pc(pc),
        .s(s), .b(b), .exe_cmd(exe_cmd),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
        .wb_en_out(wb_en_out), .carry(carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    dest;
        logic [23:0]   branch_imm;
        logic          imm;
        logic [11:0]   shift_operand;
        logic [DW-1:0] rn_value;
        logic [DW-1:0] rm_value;
        logic [DW-1:0] pc;
        logic          s;
        logic          b;
        logic [3:0]    exe_cmd;
        logic          mem_w_en;
        logic          mem_r_en;
        logic          wb_en;
        logic          carry;
    } exp_t;

    exp_t          mq[$];
    logic [DW-1:0] mregs [16];
    int            n_tests = 0;
    int            n_fail = 0;

    // ALU opcode -> execute command; -1 marks an undefined opcode
    int alu_exe[16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mread(input logic [3:0] a);
        logic [DW-1:0] v;
        v = mregs[a];
        for (int k = 0; k < NP; k++) begin
            if (wb_en[k] && wb_dest[k*4 +: 4] == a) v = wb_value[k*DW +: DW];
        end
        return v;
    endfunction

    function automatic bit is_store(input logic [31:0] ins);
        return ins[27:26] == 2'b01 && !ins[20];
    endfunction

    function automatic bit cond_holds(input logic [3:0] cc, input logic [3:0] st);
        bit n, z, c, v;
        n = st[3]; z = st[2]; c = st[1]; v = st[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic exp_t model_entry();
        exp_t e;
        int   op;
        e = '{default: '0};
        op = int'(instruction[24:21]);
        case (instruction[27:26])
            2'b00: begin
                e.s = instruction[20];
                if (alu_exe[op] >= 0) begin
                    e.exe_cmd = 4'(alu_exe[op]);
                    e.wb_en = !(op == 8 || op == 10);
                end
            end
            2'b01: begin
                e.exe_cmd = 4'd2;
                e.mem_r_en = instruction[20];
                e.wb_en = instruction[20];
                e.mem_w_en = !instruction[20];
            end
            2'b10: e.b = 1'b1;
            default: ;
        endcase
        if (!cond_holds(instruction[31:28], status)) begin
            e.s = 0; e.b = 0; e.exe_cmd = 0;
            e.mem_w_en = 0; e.mem_r_en = 0; e.wb_en = 0;
        end
        e.dest = instruction[15:12];
        e.branch_imm = instruction[23:0];
        e.imm = instruction[25];
        e.shift_operand = instruction[11:0];
        e.rn_value = mread(instruction[19:16]);
        e.rm_value = mread(is_store(instruction) ? instruction[15:12]
                                                 : instruction[3:0]);
        e.pc = pc_in;
        e.carry = status[1];
        return e;
    endfunction

    task automatic check_comb();
        chk("rn_addr", rn_addr, instruction[19:16]);
        chk("rm_addr", rm_addr, is_store(instruction) ? instruction[15:12]
                                                      : instruction[3:0]);
        chk("two_src", two_src, !instruction[25] || is_store(instruction));
        chk("in_ready", in_ready, mq.size() < DP && !hazard && !flush);
    endtask

    task automatic check_state();
        chk("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("dest", dest, mq[0].dest);
            chk("branch_imm", branch_imm, mq[0].branch_imm);
            chk("imm", imm, mq[0].imm);
            chk("shift_operand", shift_operand, mq[0].shift_operand);
            chk("rn_value", rn_value, mq[0].rn_value);
            chk("rm_value", rm_value, mq[0].rm_value);
            chk("pc", pc, mq[0].pc);
            chk("s", s, mq[0].s);
            chk("b", b, mq[0].b);
            chk("exe_cmd", exe_cmd, mq[0].exe_cmd);
            chk("mem_w_en", mem_w_en, mq[0].mem_w_en);
            chk("mem_r_en", mem_r_en, mq[0].mem_r_en);
            chk("wb_en_out", wb_en_out, mq[0].wb_en);
            chk("carry", carry, mq[0].carry);
        end
    endtask

    // Called just after a rising edge with inputs already set
    task automatic tick();
        exp_t e;
        bit   push, pop;
        #1;
        check_comb();
        push = in_valid && mq.size() < DP && !hazard && !flush;
        pop  = mq.size() != 0 && out_ready && !flush;
        if (push) e = model_entry();
        if (flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
        end
        for (int k = 0; k < NP; k++) begin
            if (wb_en[k]) mregs[wb_dest[k*4 +: 4]] = wb_value[k*DW +: DW];
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; hazard = 0; out_ready = 1;
        wb_en = '0; wb_dest = '0; wb_value = '0;
        status = '0; instruction = '0; pc_in = '0;
    endtask

    task automatic rand_inputs();
        in_valid  = $urandom_range(0, 9) < 7;
        out_ready = $urandom_range(0, 9) < 6;
        hazard    = $urandom_range(0, 9) == 0;
        flush     = $urandom_range(0, 24) == 0;
        instruction = $urandom;
        if ($urandom_range(0, 2) != 0) instruction[31:28] = 4'hE;
        instruction[27:26] = 2'($urandom_range(0, 3));
        status   = 4'($urandom);
        wb_en    = NP'($urandom);
        wb_dest  = (4*NP)'($urandom);
        if ($urandom_range(0, 1) == 1) wb_dest[3:0] = instruction[19:16];
        wb_value = {$urandom, $urandom};
        pc_in    = $urandom;
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 16; i++) mregs[i] = '0;
    endtask

    initial begin
        rst = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_pc", pc, 0);
        chk("rst_exe_cmd", exe_cmd, 0);
        chk("rst_rn_value", rn_value, 0);
        rst = 1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        idle(); wb_en = 2'b01; wb_dest = 8'h03; wb_value = 64'hAA;
        tick();
        idle(); in_valid = 1; instruction = 32'hE0831002; pc_in = 32'h100;
        tick();
        chk("add_valid", out_valid, 1);
        chk("add_rn", rn_value, 32'hAA);
        chk("add_pc", pc, 32'h100);
        chk("add_exe", exe_cmd, 4'b0010);

        idle(); wb_en = 2'b01; wb_dest = 8'h05; wb_value = 64'h1234;
        in_valid = 1; instruction = 32'hE0851002; pc_in = 32'h104;
        tick();
        chk("bypass_rn", rn_value, 32'h1234);
        chk("bypass_pc", pc, 32'h104);

        idle(); tick();
        idle(); out_ready = 0; in_valid = 1; instruction = 32'hE0831002;
        pc_in = 32'h200; tick();
        pc_in = 32'h204; tick();
        pc_in = 32'h208; #1;
        chk("full_in_ready", in_ready, 0);
        tick();
        chk("full_head", pc, 32'h200);
        idle(); tick();
        chk("order_second", pc, 32'h204);
        tick();
        chk("order_drained", out_valid, 0);

        idle(); in_valid = 1; instruction = 32'h00831002; pc_in = 32'h300;
        tick();
        chk("ccfail_valid", out_valid, 1);
        chk("ccfail_exe", exe_cmd, 0);
        chk("ccfail_wb", wb_en_out, 0);
        chk("ccfail_rn", rn_value, 32'hAA);

        idle(); tick();
        idle(); out_ready = 0; in_valid = 1; instruction = 32'hE0831002;
        tick(); tick();
        chk("pre_flush_valid", out_valid, 1);
        flush = 1; tick();
        chk("flush_valid", out_valid, 0);
        idle(); tick();
        chk("post_flush_valid", out_valid, 0);

        idle(); wb_en = 2'b11; wb_dest = 8'h77;
        wb_value = {32'h22, 32'h11};
        tick();
        idle(); in_valid = 1; instruction = 32'hE0871002; pc_in = 32'h400;
        tick();
        chk("wb_prio_rn", rn_value, 32'h22);
        hazard = 1; #1;
        chk("hazard_in_ready", in_ready, 0);
        tick();
        chk("hazard_drain", out_valid, 0);

        repeat (1500) begin
            rand_inputs();
            tick();
        end

        rst = 0;
        #1;
        model_reset();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_rn", rn_value, 0);
        idle();
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("midrst_rel_ready", in_ready, 1);

        repeat (500) begin
            rand_inputs();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameters: DATA_W 32, register data width; WB_PORTS 1, write-back channels (1..4); DEPTH 2, output buffer entries (1..4); BYPASS 1, write-to-read forwarding enable.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1 / in_ready  out  1  instruction handshake; transfer when both high.
REQ-005 instruction  in  32 / pc_in  in  DATA_W  fetched word and its PC.
REQ-006 flush  in  1 / hazard  in  1 / status  in  4  {N,Z,C,V} = bits 3,2,1,0.
REQ-007 wb_en  in  WB_PORTS / wb_dest  in  4*WB_PORTS / wb_value  in  DATA_W*WB_PORTS  write-back channels, port k in slice k.
REQ-008 rn_addr, rm_addr  out  4 / two_src  out  1  combinational, from current instruction, for hazard unit.
REQ-009 out_valid  out  1 / out_ready  in  1  execute-side handshake.
REQ-010 Out bundle: dest 4, branch_imm 24, imm 1, shift_operand 12, rn_value DATA_W, rm_value DATA_W, pc DATA_W, s, b 1 each, exe_cmd 4, mem_w_en, mem_r_en, wb_en_out, carry 1 each.

Function
REQ-011 rn_addr = instruction[19:16]; rm_addr = instruction[15:12] when decoded mem_w_en else instruction[3:0]; two_src = ~instruction[25] | decoded mem_w_en.
REQ-012 Control bits (s, b, exe_cmd, mem_w_en, mem_r_en, wb_en_out) come from the existing controller block on instruction[27:26], [24:21], [20].
REQ-013 Condition check on instruction[31:28] against status sampled in the accept cycle; failed condition enqueues entry with all control bits zero, data fields intact.
REQ-014 in_ready = (count < DEPTH) & ~hazard & ~flush; no combinational path from out_ready to in_ready.
REQ-015 Accept pushes one entry: dest=instr[15:12], branch_imm=instr[23:0], imm=instr[25], shift_operand=instr[11:0], operands, pc_in, controls, carry=status[1].
REQ-016 Output buffer FIFO of DEPTH entries; out_valid = (count != 0); out bundle = head entry; pop on out_valid & out_ready.
REQ-017 Push and pop same cycle: count unchanged, order preserved; full buffer with pop accepts nothing that cycle.
REQ-018 hazard=1: no accept, buffer still drains; instruction must be re-presented.
REQ-019 flush=1 (synchronous): count -> 0, pointers -> 0, no push, pop suppressed; out_valid low next cycle.
REQ-020 Register file: 16 x DATA_W, two asynchronous read ports (rn_addr, rm_addr), WB_PORTS synchronous write ports.
REQ-021 Same-cycle writes to one register: highest-index port wins.
REQ-022 BYPASS=1: read address matching an enabled write port returns that wb_value (highest index wins); BYPASS=0: returns stored value.
REQ-023 Latency: accepted instruction visible at output next cycle when buffer was empty.
REQ-024 Count width $clog2(DEPTH+1); pointers wrap modulo DEPTH.

Reset
REQ-025 rst low: count, pointers 0; out_valid 0; all registers and buffer entries 0; all outputs 0 except combinational rn_addr, rm_addr, two_src.
REQ-026 Reset mid-transfer discards buffered entries; in_ready high in first cycle after release if hazard, flush low.

Structure
REQ-027 Shared package holds REG_ADDR_W=4, STATUS bit indices, exe_cmd encodings, condition-code enum.
REQ-028 One sub-module id_regfile (parametrised DATA_W, WB_PORTS, BYPASS); controller and condition-check blocks reused as instances.

Verification
REQ-029 Write R3=0x0000_00AA via port 0, then ADD with Rn=3, out_ready=1 -> next cycle out_valid=1, rn_value=0xAA, pc equals pc_in.
REQ-030 BYPASS=1, same-cycle write R5=0x1234 and read rn_addr=5 -> accepted rn_value=0x1234; BYPASS=0 -> old value.
REQ-031 out_ready=0, DEPTH=2, three in_valid cycles -> two accepted, in_ready=0 third cycle; release -> entries emerge in order.
REQ-032 cond=EQ (0000), status Z=0 -> entry emitted with exe_cmd=0, wb_en_out=0, mem_w_en=0, b=0.
REQ-033 Buffer holds 2 entries, flush=1 with in_valid=1 -> out_valid=0 next cycle, no entry accepted.
REQ-034 WB_PORTS=2, both write R7 (0x11 port 0, 0x22 port 1) -> R7=0x22; hazard=1 -> in_ready=0, buffer drains.
